// File: rtl/local_predictor_bank.sv
// ----------------------------------------------------------------------------
// local_predictor_bank
//
// Banked table of 2-bit saturating branch-direction counters. There is one
// bank per global-history code (UU=0, UT=1, TU=2, TT=3). The fetch-side
// history code picks the read bank and the fetch PC picks the entry inside
// it. The execute side writes resolved branch outcomes back into the bank
// that was selected when that branch was fetched.
//
// Interface contract: there is no valid/ready handshake. The prediction is
// valid every cycle and the fetch stage uses it only when it decodes a
// branch. The execute side writes exactly once in every cycle where
// branch_op_e_i[0]=1 and stall_e_i=0. It never waits and is never
// back-pressured.
//
// Ports
//   clk_i           in   1      clock; all state updates on posedge
//   reset_n_i       in   1      asynchronous active-low reset (all counters -> 01)
//   local_src_f_i   in   2      history code at fetch; selects read bank
//   pc_f_i          in   WIDTH  fetch PC
//   local_src_e_i   in   2      history code captured at fetch, seen in execute
//   pc_e_i          in   WIDTH  PC of the resolving branch
//   branch_op_e_i   in   2      branch op; bit 0 marks a conditional branch
//   pc_src_res_e_i  in   1      resolved outcome (1 = taken)
//   stall_e_i       in   1      execute stage stalled
//   pred_taken_f_o  out  1      predicted taken (MSB of selected counter)
//   pred_state_f_o  out  2      selected counter value
// ----------------------------------------------------------------------------
module local_predictor_bank #(
  parameter int WIDTH      = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic [1:0]       local_src_f_i,
  input  logic [WIDTH-1:0] pc_f_i,
  input  logic [1:0]       local_src_e_i,
  input  logic [WIDTH-1:0] pc_e_i,
  input  logic [1:0]       branch_op_e_i,
  input  logic             pc_src_res_e_i,
  input  logic             stall_e_i,
  output logic             pred_taken_f_o,
  output logic [1:0]       pred_state_f_o
);

  localparam int DEPTH = 1 << INDEX_BITS;

  // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
  localparam logic [1:0] CNT_RESET = 2'b01;

  logic [1:0] cnt_q [4][DEPTH];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] wr_idx;
  logic                  upd;
  logic                  bypass;
  logic [1:0]            rd_entry;
  logic [1:0]            wr_entry;
  logic [1:0]            wr_nxt;

  // PC bits below the word offset and above the index are deliberately
  // ignored. PCs 4*DEPTH bytes apart alias onto the same entry, and that
  // aliasing is accepted. branch_op_e_i[1] does not affect qualification.
  logic unused_bits;
  assign unused_bits = ^{pc_f_i[1:0], pc_f_i[WIDTH-1:INDEX_BITS+2],
                         pc_e_i[1:0], pc_e_i[WIDTH-1:INDEX_BITS+2],
                         branch_op_e_i[1]};

  function automatic logic [1:0] sat_nxt(input logic [1:0] c, input logic t);
    logic [1:0] r;
    if (t) r = (c == 2'b11) ? 2'b11 : c + 2'b01;
    else   r = (c == 2'b00) ? 2'b00 : c - 2'b01;
    return r;
  endfunction

  assign rd_idx = pc_f_i[INDEX_BITS+1:2];
  assign wr_idx = pc_e_i[INDEX_BITS+1:2];

  // Same qualifier the GHR uses to advance, so table and history stay in step.
  assign upd = branch_op_e_i[0] & ~stall_e_i;

  assign rd_entry = cnt_q[local_src_f_i][rd_idx];
  assign wr_entry = cnt_q[local_src_e_i][wr_idx];

  // Gate wr_nxt with upd so a floating outcome bit on idle cycles never
  // reaches any storage or output path.
  assign wr_nxt = upd ? sat_nxt(wr_entry, pc_src_res_e_i) : wr_entry;

  // Write-first view when fetch reads the entry being written this cycle.
  // The bypass is held off during reset so the outputs show the forced 01
  // rather than a write that reset is about to discard.
  assign bypass = upd && reset_n_i &&
                  (local_src_f_i == local_src_e_i) && (rd_idx == wr_idx);

  always_comb begin
    pred_state_f_o = rd_entry;
    if (bypass) pred_state_f_o = wr_nxt;
    pred_taken_f_o = pred_state_f_o[1];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          cnt_q[b][i] <= CNT_RESET;
        end
      end
    end else if (upd) begin
      cnt_q[local_src_e_i][wr_idx] <= wr_nxt;
    end
  end

endmodule

// File: tb/tb_local_predictor_bank.sv
module tb_local_predictor_bank;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [1:0]  local_src_f_i;
  logic [31:0] pc_f_i;
  logic [1:0]  local_src_e_i;
  logic [31:0] pc_e_i;
  logic [1:0]  branch_op_e_i;
  logic        pc_src_res_e_i;
  logic        stall_e_i;
  logic        pred_taken_f_o;
  logic [1:0]  pred_state_f_o;

  always #5 clk_i = ~clk_i;

  local_predictor_bank #(.WIDTH(32), .INDEX_BITS(6)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .local_src_f_i  (local_src_f_i),
    .pc_f_i         (pc_f_i),
    .local_src_e_i  (local_src_e_i),
    .pc_e_i         (pc_e_i),
    .branch_op_e_i  (branch_op_e_i),
    .pc_src_res_e_i (pc_src_res_e_i),
    .stall_e_i      (stall_e_i),
    .pred_taken_f_o (pred_taken_f_o),
    .pred_state_f_o (pred_state_f_o)
  );

  // ---------------- reference model ----------------
  // Each counter is a plain integer in 0..3 that moves up or down and clamps.
  int model_c [4][64];

  function automatic void model_reset();
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 64; i++)
        model_c[b][i] = 1;
  endfunction

  function automatic int entry_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic int model_nxt(input int c, input logic t);
    if (t === 1'b1) return (c < 3) ? c + 1 : 3;
    return (c > 0) ? c - 1 : 0;
  endfunction

  function automatic logic [1:0] model_read(
      input logic [1:0] bf, input logic [31:0] pcf,
      input logic [1:0] be, input logic [31:0] pce,
      input logic [1:0] op, input logic res, input logic stall);
    int v;
    v = model_c[bf][entry_of(pcf)];
    if ((op % 2 == 1) && !stall && bf == be && entry_of(pcf) == entry_of(pce))
      v = model_nxt(model_c[be][entry_of(pce)], res);
    return 2'(v);
  endfunction

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  int checks = 0;
  int passes = 0;

  task automatic check_out(input string name);
    logic [1:0] e;
    logic       et;
    e  = exp_q.pop_front();
    et = (e >= 2'd2);
    checks++;
    if (pred_state_f_o === e) passes++;
    else $display("FAIL %s: pred_state_f_o=%b expected %b", name, pred_state_f_o, e);
    checks++;
    if (pred_taken_f_o === et) passes++;
    else $display("FAIL %s: pred_taken_f_o=%b expected %b", name, pred_taken_f_o, et);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] bf, input logic [31:0] pcf,
                       input logic [1:0] be, input logic [31:0] pce,
                       input logic [1:0] op, input logic res, input logic stall);
    local_src_f_i  = bf;
    pc_f_i         = pcf;
    local_src_e_i  = be;
    pc_e_i         = pce;
    branch_op_e_i  = op;
    pc_src_res_e_i = res;
    stall_e_i      = stall;
  endtask

  // Called at a negedge: drive, check mid-cycle, clock, update model.
  task automatic run_cycle(input logic [1:0] bf, input logic [31:0] pcf,
                           input logic [1:0] be, input logic [31:0] pce,
                           input logic [1:0] op, input logic res, input logic stall,
                           input string name, input bit use_const,
                           input logic [1:0] const_exp);
    drive(bf, pcf, be, pce, op, res, stall);
    if (use_const) exp_q.push_back(const_exp);
    else           exp_q.push_back(model_read(bf, pcf, be, pce, op, res, stall));
    #1;
    check_out(name);
    @(posedge clk_i);
    if (reset_n_i && (op % 2 == 1) && !stall)
      model_c[be][entry_of(pce)] = model_nxt(model_c[be][entry_of(pce)], res);
    @(negedge clk_i);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  bf;
    logic [31:0] pcf;
    logic [1:0]  be;
    logic [31:0] pce;
    logic [1:0]  op;
    logic        res;
    logic        stall;
    logic [1:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [1:0] bf, input logic [31:0] pcf,
                                  input logic [1:0] be, input logic [31:0] pce,
                                  input logic [1:0] op, input logic res,
                                  input logic stall, input logic [1:0] exp,
                                  input string name);
    vec_t v;
    v.bf = bf; v.pcf = pcf; v.be = be; v.pce = pce; v.op = op;
    v.res = res; v.stall = stall; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    // taken saturation, bank 1 / 0x40; bank 0 same PC untouched
    add_vec(0, 32'h40, 1, 32'h40, 1, 1, 0, 2'b01, "sat_t_b0_a");
    add_vec(1, 32'h40, 0, 32'h0,  0, 0, 0, 2'b10, "sat_t_1");
    add_vec(0, 32'h40, 1, 32'h40, 1, 1, 0, 2'b01, "sat_t_b0_b");
    add_vec(1, 32'h40, 0, 32'h0,  0, 0, 0, 2'b11, "sat_t_2");
    add_vec(0, 32'h40, 1, 32'h40, 1, 1, 0, 2'b01, "sat_t_b0_c");
    add_vec(1, 32'h40, 0, 32'h0,  0, 0, 0, 2'b11, "sat_t_3");
    // not-taken saturation, bank 2 / 0x80, then one taken
    add_vec(3, 32'h80, 2, 32'h80, 1, 0, 0, 2'b01, "sat_nt_other_a");
    add_vec(2, 32'h80, 0, 32'h0,  0, 0, 0, 2'b00, "sat_nt_1");
    add_vec(3, 32'h80, 2, 32'h80, 1, 0, 0, 2'b01, "sat_nt_other_b");
    add_vec(2, 32'h80, 0, 32'h0,  0, 0, 0, 2'b00, "sat_nt_2");
    add_vec(3, 32'h80, 2, 32'h80, 1, 1, 0, 2'b01, "sat_nt_other_c");
    add_vec(2, 32'h80, 0, 32'h0,  0, 0, 0, 2'b01, "sat_nt_recover");
    // qualifiers: stalled or not a conditional branch -> no update
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) add_vec(0, 32'h10, 0, 32'h10, 1, 1, 1, 2'b01, "qual_stall");
      else            add_vec(0, 32'h10, 0, 32'h10, 2, 1, 0, 2'b01, "qual_op0");
    end
    add_vec(0, 32'h10, 0, 32'h0, 0, 0, 0, 2'b01, "qual_final");
    // same-cycle bypass, bank 3 / 0x24
    add_vec(3, 32'h24, 3, 32'h24, 1, 1, 0, 2'b10, "bypass_hit");
    add_vec(2, 32'h24, 3, 32'h24, 1, 1, 0, 2'b01, "bypass_other_bank");
    add_vec(3, 32'h24, 0, 32'h0,  0, 0, 0, 2'b11, "bypass_after");
    add_vec(3, 32'h24, 3, 32'h24, 3, 0, 0, 2'b10, "op_bit1_bypass");
    add_vec(3, 32'h24, 0, 32'h0,  0, 0, 0, 2'b10, "op_bit1_stored");
    // aliasing: update 0x40 bank 0, visible at 0x140 and at high-bit alias
    add_vec(2, 32'h0,  0, 32'h40, 1, 1, 0, 2'b01, "alias_upd");
    add_vec(0, 32'h140, 0, 32'h0, 0, 0, 0, 2'b10, "alias_0x140");
    add_vec(0, 32'h1234_5143, 0, 32'h0, 0, 0, 0, 2'b10, "alias_hi_bits");
  end

  // ---------------- test sequence ----------------
  initial begin
    reset_n_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk_i);

    // reset sweep with an active same-entry update that reset must hide
    for (int b = 0; b < 4; b++) begin
      for (int p = 0; p < 256; p += 4) begin
        drive(2'(b), 32'(p), 2'(b), 32'(p), 1, 1, 0);
        exp_q.push_back(2'b01);
        #1;
        check_out("reset_sweep");
      end
    end
    @(negedge clk_i);
    drive(0, 0, 0, 0, 0, 0, 0);
    reset_n_i = 1'b1;

    foreach (vecs[k])
      run_cycle(vecs[k].bf, vecs[k].pcf, vecs[k].be, vecs[k].pce, vecs[k].op,
                vecs[k].res, vecs[k].stall, vecs[k].name, 1'b1, vecs[k].exp);

    // async reset between edges, with an update pending on the same entry
    drive(0, 32'h140, 0, 32'h40, 1, 1, 0);
    exp_q.push_back(2'b11);
    #1;
    check_out("pre_rst_bypass");
    #2;
    reset_n_i = 1'b0;
    exp_q.push_back(2'b01);
    #1;
    check_out("async_rst_now");
    @(posedge clk_i);
    model_reset();
    @(negedge clk_i);
    exp_q.push_back(2'b01);
    #1;
    check_out("rst_held");
    @(negedge clk_i);
    drive(0, 32'h40, 0, 0, 0, 0, 0);
    reset_n_i = 1'b1;
    exp_q.push_back(2'b01);
    #1;
    check_out("rst_update_lost");
    @(negedge clk_i);

    // unknown outcome while not updating must leave state alone
    for (int i = 0; i < 4; i++)
      run_cycle(0, 32'h40, 0, 32'h40, (i % 2 == 0) ? 2'd0 : 2'd1, 1'bx,
                (i % 2 == 1), "x_res_idle", 1'b0, 2'b00);
    run_cycle(0, 32'h40, 0, 0, 0, 0, 0, "x_res_after", 1'b1, 2'b01);

    // randomized traffic on a narrow index window to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pf, pe;
      pf = $urandom;
      pe = $urandom;
      pf[7:2] = 6'($urandom_range(0, 7));
      pe[7:2] = 6'($urandom_range(0, 7));
      run_cycle(2'($urandom_range(0, 3)), pf, 2'($urandom_range(0, 3)), pe,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), "random", 1'b0, 2'b00);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
